dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2: BUSY cycles per access; legal range 1..15.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the storage array; power of two.
REQ-003 Parameter BASE_ADDR, default 32'h10000000: byte address of word 0.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 mem_read  input  1  load request from the pipeline memory stage; level, held until stall drops.
REQ-007 mem_write  input  1  store request from the pipeline memory stage; level, held until stall drops.
REQ-008 addr  input  32  byte address of the access.
REQ-009 wdata  input  32  store data.
REQ-010 rdata  output  32  load result.
REQ-011 stall  output  1  high while a request is outstanding; the pipeline freezes its PC and stage registers while stall is high.
REQ-012 error  output  1  one-cycle pulse flagging a faulted access.

Function
REQ-013 FSM states: IDLE, BUSY, DONE.
REQ-014 A request exists when mem_read XOR mem_write is high.
REQ-015 In IDLE with a request: stall is high combinationally in the same cycle; addr, wdata and the op latch; the latency counter loads LATENCY-1; next state is BUSY.
REQ-016 In BUSY: stall is high; the counter decrements each cycle; at count 0 the next state is DONE.
REQ-017 Total stall length is LATENCY+1 cycles per access, counted from the first request cycle.
REQ-018 In DONE: stall is low; rdata is valid; the next state is always IDLE; request inputs in DONE are ignored because they belong to the retiring instruction.
REQ-019 A store writes the array on the BUSY->DONE edge; a load updates rdata on the same edge with array[(addr-BASE_ADDR)>>2].
REQ-020 rdata holds its value until the next successful load completes; stores do not change rdata.
REQ-021 Fault conditions: addr[1:0]!=0, addr<BASE_ADDR, or addr>=BASE_ADDR+4*DEPTH_WORDS.
REQ-022 A faulted access still takes the full LATENCY+1 stall; it performs no array write; rdata is forced to 0 in DONE; error is high only in DONE.
REQ-023 mem_read and mem_write both high in IDLE: no access and no stall; error pulses the next cycle; the state stays IDLE.
REQ-024 Input changes while in BUSY are ignored because the latched copies are used.
REQ-025 Address offset arithmetic is a 32-bit unsigned subtraction; index width is log2(DEPTH_WORDS).

Reset
REQ-026 reset low forces IDLE, counter 0, latched registers 0, rdata 0, error 0 and stall low, immediately and asynchronously.
REQ-027 Reset mid-access aborts the access; a pending store does not reach the array.
REQ-028 Array contents are not cleared by reset.
REQ-029 Deassertion takes effect on the first rising clk edge after reset goes high.

Structure
REQ-030 Shared package dmem_pkg holds the FSM state enum, DEFAULT_LATENCY, DEFAULT_BASE_ADDR and the fault-check function.
REQ-031 The latency down-counter is a sub-module, dmem_latency_counter, with load, decrement and zero-flag outputs.
REQ-032 The storage array is inferred inside dmem_responder with a synchronous write and a registered read.

Verification (LATENCY=2, defaults)
REQ-033 Store 32'hDEADBEEF to 32'h10000008 at cycle 0 -> stall high in cycles 0-2, low in cycle 3; error stays 0.
REQ-034 Load from 32'h10000008 after REQ-033 -> rdata is 32'hDEADBEEF in the DONE cycle (cycle 3); rdata is unchanged by a following store.
REQ-035 Load from 32'h10000006 (misaligned) -> stall for 3 cycles; error=1 and rdata=0 in the DONE cycle; array is unchanged.
REQ-036 Store to 32'h10001000 (one past the end) -> error pulses in DONE; a read-back of word 0 is unaffected.
REQ-037 reset low during cycle 1 of a store to 32'h10000010 -> stall drops immediately; a later load of 32'h10000010 returns its prior value.
REQ-038 mem_read=mem_write=1 -> stall stays 0; error pulses one cycle later; the FSM stays in IDLE.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// default parameter values and the address fault check.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  localparam int unsigned DEFAULT_LATENCY   = 2;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;
  localparam int          CNT_W             = 4;

  // Offset is taken with wrapping 32-bit subtraction; the explicit addr < base
  // term catches the wrap for addresses below the window.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base_addr,
                                      input logic [31:0] depth_words);
    logic [31:0] offset;
    offset = addr - base_addr;
    return (addr[1:0] != 2'b00) ||
           (addr < base_addr) ||
           ({2'b00, offset[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_latency_counter.sv
// Down-counter that times the BUSY phase of an access; zero flags the last
// BUSY cycle.
module dmem_latency_counter
  import dmem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY+1 cycles
// per access, serves loads/stores from an internal array, flags faults.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY     = DEFAULT_LATENCY,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        error
);

  localparam int             IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);
  localparam logic [31:0]    DEPTH_W32 = 32'(DEPTH_WORDS);

  dmem_state_e state_q, state_d;

  logic             req, conflict;
  logic             stall_c, latch_en, cnt_load, cnt_dec, cnt_zero, complete;
  logic [31:0]      addr_q, wdata_q;
  logic             is_write_q, fault_q;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem [DEPTH_WORDS];

  assign req      = mem_read ^ mem_write;
  assign conflict = mem_read & mem_write;

  dmem_latency_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    latch_en = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall_c  = 1'b1;
          latch_en = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        if (cnt_zero) begin
          complete = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      // Inputs seen here belong to the retiring instruction.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall is combinational from the request, so reset must mask it directly.
  assign stall = stall_c & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      fault_q    <= 1'b0;
    end else if (latch_en) begin
      addr_q     <= addr;
      wdata_q    <= wdata;
      is_write_q <= mem_write;
      fault_q    <= addr_fault(addr, BASE_ADDR, DEPTH_W32);
    end
  end

  assign mem_idx = IDX_W'((addr_q - BASE_ADDR) >> 2);

  // Array has no reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (complete && is_write_q && !fault_q) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      error <= 1'b0;
    end else begin
      error <= (complete && fault_q) || ((state_q == ST_IDLE) && conflict);
      if (complete) begin
        if (fault_q) begin
          rdata <= '0;
        end else if (!is_write_q) begin
          rdata <= mem[mem_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios followed by random accesses,
// all checked against a word-addressed memory model.
module tb_dmem_responder;

  localparam int          LAT   = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset, mem_read, mem_write, stall, error;
  logic [31:0] addr, wdata, rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [int];
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  dmem_responder #(
    .LATENCY     (LAT),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .error     (error)
  );

  function automatic bit model_fault(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (a % 4 != 0) || (off < 0) || (off >= longint'(4 * DEPTH));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase once the
  // DONE cycle has been checked and the request withdrawn.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    bit f;
    int idx;
    f = model_fault(a);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    for (int c = 0; c <= LAT; c++) begin
      #3;
      check({tag, " stall"}, 32'(stall), 32'd1);
      check({tag, " busy_error"}, 32'(error), 32'd0);
      check({tag, " busy_rdata"}, rdata, exp_rdata);
      @(posedge clk); #1;
      if (c == 0) begin
        addr  = $urandom;
        wdata = $urandom;
      end
    end
    if (f) begin
      exp_rdata = '0;
    end else begin
      idx = int'((a - BASE) / 4);
      if (rd) exp_rdata = model_mem[idx];
      else    model_mem[idx] = d;
    end
    #3;
    check({tag, " done_stall"}, 32'(stall), 32'd0);
    check({tag, " done_error"}, 32'(error), 32'(f));
    check({tag, " done_rdata"}, rdata, exp_rdata);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    int          r;
    bit          rd;

    reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    #2;
    check("reset stall", 32'(stall), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset rdata", rdata, 32'd0);
    mem_read = 1'b1; #1;
    check("reset masks stall", 32'(stall), 32'd0);
    mem_read = 1'b0;
    #5 reset = 1'b1;
    @(posedge clk); #1;

    access(0, 1, 32'h1000_0008, 32'hDEAD_BEEF, "store_8");
    access(1, 0, 32'h1000_0008, 32'h0, "load_8");
    access(0, 1, 32'h1000_000C, 32'h1234_5678, "store_c");
    check("rdata held after store", rdata, 32'hDEAD_BEEF);
    access(0, 1, 32'h1000_0000, 32'hA5A5_0000, "store_0");

    access(1, 0, 32'h1000_0006, 32'h0, "load_misaligned");
    access(1, 0, 32'h1000_0008, 32'h0, "load_8_again");
    access(0, 1, 32'h1000_1000, 32'h5555_AAAA, "store_past_end");
    access(1, 0, 32'h1000_0000, 32'h0, "load_0");
    access(1, 0, 32'h0FFF_FFFC, 32'h0, "load_below_base");
    access(0, 1, BASE + 4 * (DEPTH - 1), 32'h0F0F_F0F0, "store_last");
    access(1, 0, BASE + 4 * (DEPTH - 1), 32'h0, "load_last");

    // Read and write together: no access, no stall, error one cycle later.
    mem_read = 1'b1; mem_write = 1'b1; addr = BASE; wdata = 32'hFFFF_FFFF;
    #3;
    check("conflict stall", 32'(stall), 32'd0);
    check("conflict error_now", 32'(error), 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    #3;
    check("conflict error_next", 32'(error), 32'd1);
    check("conflict stall_next", 32'(stall), 32'd0);
    @(posedge clk); #1;
    #3;
    check("conflict error_clear", 32'(error), 32'd0);
    @(posedge clk); #1;
    access(1, 0, 32'h1000_0000, 32'h0, "load_0_after_conflict");

    // Reset in the middle of a store.
    access(0, 1, 32'h1000_0010, 32'h0BAD_F00D, "store_10_prior");
    mem_write = 1'b1; addr = 32'h1000_0010; wdata = 32'hCAFE_0001;
    #3;
    check("abort stall_c0", 32'(stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("abort stall", 32'(stall), 32'd0);
    check("abort error", 32'(error), 32'd0);
    check("abort rdata", rdata, 32'd0);
    exp_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    mem_write = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset stall", 32'(stall), 32'd0);
    access(1, 0, 32'h1000_0010, 32'h0, "load_10_after_abort");

    // Random phase over a small window plus fault addresses.
    for (int i = 0; i < 16; i++) begin
      access(0, 1, BASE + 32'(4 * i), $urandom, "fill");
    end
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      rd = 1'($urandom_range(0, 1));
      if (r < 7)       ra = BASE + 4 * $urandom_range(0, 15);
      else if (r == 7) ra = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else if (r == 8) ra = BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
      else             ra = BASE - 4 * $urandom_range(1, 16);
      access(rd, !rd, ra, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
